prog_launch_ctrl: RTL and testbench

- Host-side run controller sitting directly upstream of the processor top level.
- Drives the processor's Start input and consumes its Ack (done) flag.
- Launches a programmed number of back-to-back program runs.
- Measures cycles per run, accumulates the total, and aborts on a watchdog timeout.
- Replaces hand-sequenced Start/Ack pokes in benches and gives synthesizable run control for board bring-up.

---
 rtl/prog_launch_ctrl_if.sv | 27 ++
 rtl/prog_launch_ctrl.sv | 148 ++++++++++++++
 tb/tb_prog_launch_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/prog_launch_ctrl_if.sv
// Host/processor run-control bundle for prog_launch_ctrl.
// The master side is the host plus processor model; the slave side is the controller.
interface prog_launch_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int RUNS_W = 8
);
  logic              HostGo;
  logic [RUNS_W-1:0] NumRuns;
  logic              Start;
  logic              Ack;
  logic              Busy;
  logic              Done;
  logic              TimedOut;
  logic [RUNS_W-1:0] RunIdx;
  logic [CNT_W-1:0]  CycleCount;
  logic [CNT_W-1:0]  TotalCycles;

  modport master (
    output HostGo, NumRuns, Ack,
    input  Start, Busy, Done, TimedOut, RunIdx, CycleCount, TotalCycles
  );

  modport slave (
    input  HostGo, NumRuns, Ack,
    output Start, Busy, Done, TimedOut, RunIdx, CycleCount, TotalCycles
  );
endinterface

// File: rtl/prog_launch_ctrl.sv
// Batch run controller: pulses processor Start, times each run to Ack,
// accumulates a saturating total and aborts a run on watchdog timeout.
module prog_launch_ctrl #(
  parameter int CNT_W     = 32,
  parameter int RUNS_W    = 8,
  parameter int START_LEN = 1,
  parameter int TIMEOUT   = 100000
) (
  input  logic              Clk,
  input  logic              Reset,
  prog_launch_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [3:0]       START_LEN_C = 4'(START_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_RUN    = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t            state_q;
  logic              start_q;
  logic              done_q;
  logic              timedout_q;
  logic [3:0]        slen_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RUNS_W-1:0] nruns_q;
  logic [RUNS_W-1:0] runidx_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  total_q;

  logic [CNT_W-1:0]  cnt_d;
  logic [RUNS_W-1:0] runidx_d;
  logic              tmo_hit;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // cnt_d is the run length including the current cycle.
  always_comb begin
    cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    runidx_d = runidx_q + RUNS_W'(1);
    tmo_hit  = (cnt_d >= TIMEOUT_C);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      timedout_q <= 1'b0;
      slen_q     <= '0;
      cnt_q      <= '0;
      nruns_q    <= '0;
      runidx_q   <= '0;
      cyc_q      <= '0;
      total_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.HostGo) begin
            nruns_q    <= bus.NumRuns;
            runidx_q   <= '0;
            cyc_q      <= '0;
            total_q    <= '0;
            timedout_q <= 1'b0;
            cnt_q      <= '0;
            if (bus.NumRuns != '0) begin
              state_q <= S_LAUNCH;
              start_q <= 1'b1;
              slen_q  <= 4'd1;
            end else begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          cnt_q <= cnt_d;
          if (slen_q == START_LEN_C) begin
            state_q <= S_ARM;
            start_q <= 1'b0;
          end else begin
            slen_q <= slen_q + 4'd1;
          end
        end
        // A stale Ack from the previous run must drop before timing starts to count completion.
        S_ARM: begin
          cnt_q <= cnt_d;
          if (tmo_hit) begin
            timedout_q <= 1'b1;
            state_q    <= S_FIN;
            done_q     <= 1'b1;
          end else if (!bus.Ack) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_d;
          if (bus.Ack) begin
            cyc_q    <= cnt_d;
            total_q  <= sat_add(total_q, cnt_d);
            runidx_q <= runidx_d;
            if (runidx_d == nruns_q) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_LAUNCH;
              start_q <= 1'b1;
              slen_q  <= 4'd1;
              cnt_q   <= '0;
            end
          end else if (tmo_hit) begin
            timedout_q <= 1'b1;
            state_q    <= S_FIN;
            done_q     <= 1'b1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          start_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Start       = start_q;
  assign bus.Busy        = (state_q != S_IDLE);
  assign bus.Done        = done_q;
  assign bus.TimedOut    = timedout_q;
  assign bus.RunIdx      = runidx_q;
  assign bus.CycleCount  = cyc_q;
  assign bus.TotalCycles = total_q;

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// Directed bench for prog_launch_ctrl with START_LEN=1 and TIMEOUT=50.
module tb_prog_launch_ctrl;
  localparam int CNT_W     = 32;
  localparam int RUNS_W    = 8;
  localparam int START_LEN = 1;
  localparam int TIMEOUT   = 50;

  logic Clk = 1'b0;
  logic Reset;
  int   vectors = 0;
  int   miscompares = 0;

  prog_launch_ctrl_if #(.CNT_W(CNT_W), .RUNS_W(RUNS_W)) bus ();

  prog_launch_ctrl #(
    .CNT_W(CNT_W), .RUNS_W(RUNS_W), .START_LEN(START_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered on the first Start cycle of a run; Ack is high during cycle 'len'.
  task automatic run_once(input int len, input string tag);
    chk({tag, "_start_hi"}, 64'(bus.Start), 64'd1);
    tick();
    bus.HostGo = 1'b0;
    bus.Ack    = 1'b0;
    chk({tag, "_start_lo"}, 64'(bus.Start), 64'd0);
    repeat (len - 2) tick();
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
  endtask

  initial begin
    Reset       = 1'b0;
    bus.HostGo  = 1'b0;
    bus.NumRuns = '0;
    bus.Ack     = 1'b0;
    repeat (3) tick();
    chk("rst_start", 64'(bus.Start), 64'd0);
    chk("rst_busy",  64'(bus.Busy),  64'd0);
    chk("rst_done",  64'(bus.Done),  64'd0);
    chk("rst_tmo",   64'(bus.TimedOut), 64'd0);
    chk("rst_idx",   64'(bus.RunIdx), 64'd0);
    chk("rst_cyc",   64'(bus.CycleCount), 64'd0);
    chk("rst_tot",   64'(bus.TotalCycles), 64'd0);
    Reset = 1'b1;
    tick();

    // Single run of 22 cycles, Ack stale high until after Start.
    bus.HostGo = 1'b1; bus.NumRuns = 8'd1; bus.Ack = 1'b1;
    tick();
    chk("a_busy", 64'(bus.Busy), 64'd1);
    run_once(22, "a");
    chk("a_done", 64'(bus.Done), 64'd1);
    chk("a_cyc",  64'(bus.CycleCount), 64'd22);
    chk("a_tot",  64'(bus.TotalCycles), 64'd22);
    chk("a_idx",  64'(bus.RunIdx), 64'd1);
    chk("a_start_fin", 64'(bus.Start), 64'd0);
    tick();
    chk("a_done_once", 64'(bus.Done), 64'd0);
    chk("a_busy_lo",   64'(bus.Busy), 64'd0);

    // Three back-to-back runs 10/15/5; HostGo and NumRuns poked while busy.
    bus.HostGo = 1'b1; bus.NumRuns = 8'd3;
    tick();
    bus.HostGo = 1'b0; bus.NumRuns = 8'd7;
    run_once(10, "b1");
    chk("b1_cyc",  64'(bus.CycleCount), 64'd10);
    chk("b1_idx",  64'(bus.RunIdx), 64'd1);
    chk("b1_tot",  64'(bus.TotalCycles), 64'd10);
    chk("b1_done", 64'(bus.Done), 64'd0);
    bus.HostGo = 1'b1;
    run_once(15, "b2");
    chk("b2_cyc",  64'(bus.CycleCount), 64'd15);
    chk("b2_idx",  64'(bus.RunIdx), 64'd2);
    chk("b2_tot",  64'(bus.TotalCycles), 64'd25);
    run_once(5, "b3");
    chk("b3_done", 64'(bus.Done), 64'd1);
    chk("b3_cyc",  64'(bus.CycleCount), 64'd5);
    chk("b3_idx",  64'(bus.RunIdx), 64'd3);
    chk("b3_tot",  64'(bus.TotalCycles), 64'd30);
    chk("b3_tmo",  64'(bus.TimedOut), 64'd0);
    bus.HostGo = 1'b1; bus.NumRuns = 8'd2;
    tick();
    bus.HostGo = 1'b0;
    chk("b_fin_go_busy", 64'(bus.Busy), 64'd0);
    tick();
    chk("b_fin_go_start", 64'(bus.Start), 64'd0);
    chk("b_fin_go_idle",  64'(bus.Busy), 64'd0);

    // Zero-run batch.
    bus.HostGo = 1'b1; bus.NumRuns = 8'd0;
    tick();
    bus.HostGo = 1'b0;
    chk("d_done",  64'(bus.Done), 64'd1);
    chk("d_start", 64'(bus.Start), 64'd0);
    chk("d_idx",   64'(bus.RunIdx), 64'd0);
    chk("d_cyc",   64'(bus.CycleCount), 64'd0);
    chk("d_tot",   64'(bus.TotalCycles), 64'd0);
    tick();
    chk("d_done_lo", 64'(bus.Done), 64'd0);
    chk("d_busy_lo", 64'(bus.Busy), 64'd0);

    // Stale Ack held through ARM, then no Ack at all: timeout.
    bus.Ack = 1'b1; bus.HostGo = 1'b1; bus.NumRuns = 8'd1;
    tick();
    bus.HostGo = 1'b0;
    repeat (9) tick();
    chk("c_arm_busy", 64'(bus.Busy), 64'd1);
    chk("c_arm_done", 64'(bus.Done), 64'd0);
    chk("c_arm_idx",  64'(bus.RunIdx), 64'd0);
    bus.Ack = 1'b0;
    repeat (40) tick();
    chk("c_pre_done", 64'(bus.Done), 64'd0);
    chk("c_pre_tmo",  64'(bus.TimedOut), 64'd0);
    tick();
    chk("c_done", 64'(bus.Done), 64'd1);
    chk("c_tmo",  64'(bus.TimedOut), 64'd1);
    chk("c_idx",  64'(bus.RunIdx), 64'd0);
    chk("c_cyc",  64'(bus.CycleCount), 64'd0);
    tick();
    chk("c_tmo_sticky", 64'(bus.TimedOut), 64'd1);
    chk("c_idle", 64'(bus.Busy), 64'd0);

    // Ack on exactly the timeout cycle counts as completion.
    bus.HostGo = 1'b1; bus.NumRuns = 8'd1;
    tick();
    bus.HostGo = 1'b0;
    chk("e_tmo_clr", 64'(bus.TimedOut), 64'd0);
    run_once(TIMEOUT, "e");
    chk("e_done", 64'(bus.Done), 64'd1);
    chk("e_tmo",  64'(bus.TimedOut), 64'd0);
    chk("e_cyc",  64'(bus.CycleCount), 64'(TIMEOUT));
    chk("e_idx",  64'(bus.RunIdx), 64'd1);
    tick();

    // Asynchronous reset during run 2 of 3.
    bus.HostGo = 1'b1; bus.NumRuns = 8'd3;
    tick();
    bus.HostGo = 1'b0;
    run_once(10, "f1");
    tick();
    bus.Ack = 1'b0;
    repeat (5) tick();
    #2 Reset = 1'b0;
    #1;
    chk("f_rst_start", 64'(bus.Start), 64'd0);
    chk("f_rst_busy",  64'(bus.Busy), 64'd0);
    chk("f_rst_done",  64'(bus.Done), 64'd0);
    chk("f_rst_idx",   64'(bus.RunIdx), 64'd0);
    chk("f_rst_cyc",   64'(bus.CycleCount), 64'd0);
    chk("f_rst_tot",   64'(bus.TotalCycles), 64'd0);
    tick();
    chk("f_rst_done2", 64'(bus.Done), 64'd0);
    Reset = 1'b1;
    tick();
    chk("f_rel_busy", 64'(bus.Busy), 64'd0);
    chk("f_rel_done", 64'(bus.Done), 64'd0);
    bus.HostGo = 1'b1; bus.NumRuns = 8'd1;
    tick();
    bus.HostGo = 1'b0;
    run_once(7, "g");
    chk("g_done", 64'(bus.Done), 64'd1);
    chk("g_cyc",  64'(bus.CycleCount), 64'd7);
    chk("g_idx",  64'(bus.RunIdx), 64'd1);
    chk("g_tot",  64'(bus.TotalCycles), 64'd7);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
